// File: rtl/life_step_engine.sv
// Sequential Conway Game of Life engine: holds the current grid and computes one
// generation per accepted trigger, one row per clock, then commits it atomically.
module life_step_engine #(
  parameter int GRID_N = 8,
  parameter int WRAP   = 0,
  parameter int GEN_W  = 16
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [GRID_N*GRID_N-1:0]   seed,
  input  logic                       load,
  input  logic                       run,
  input  logic                       tick,
  input  logic                       step,
  output logic [GRID_N*GRID_N-1:0]   grid,
  output logic [GEN_W-1:0]           gen_count,
  output logic                       busy,
  output logic                       halted,
  output logic                       stable,
  output logic                       extinct
);

  localparam int PTR_W = (GRID_N > 1) ? $clog2(GRID_N) : 1;
  localparam logic [PTR_W-1:0] LAST_ROW = PTR_W'(GRID_N - 1);

  typedef enum logic [1:0] {
    IDLE,
    CALC,
    COMMIT,
    HALT
  } state_t;

  state_t                   state;
  state_t                   state_next;
  logic [PTR_W-1:0]         row_ptr;
  logic [GRID_N-1:0]        next_rows [GRID_N];
  logic [GRID_N-1:0]        cur_rows  [GRID_N];
  logic [GRID_N*GRID_N-1:0] next_grid;
  logic [PTR_W-1:0]         up_idx;
  logic [PTR_W-1:0]         dn_idx;
  logic [GRID_N-1:0]        up_row;
  logic [GRID_N-1:0]        mid_row;
  logic [GRID_N-1:0]        dn_row;
  logic [GRID_N-1:0]        calc_row;
  logic                     trigger;
  logic                     next_zero;
  logic                     next_same;

  // Extends a row by one phantom column on each side: dead cells, or the
  // opposite edge column when the board is toroidal.
  function automatic logic [GRID_N+1:0] pad_row(input logic [GRID_N-1:0] row);
    logic hi;
    logic lo;
    hi = (WRAP != 0) ? row[0] : 1'b0;
    lo = (WRAP != 0) ? row[GRID_N-1] : 1'b0;
    return {hi, row, lo};
  endfunction

  function automatic logic [GRID_N-1:0] life_row(input logic [GRID_N-1:0] up,
                                                 input logic [GRID_N-1:0] mid,
                                                 input logic [GRID_N-1:0] dn);
    logic [GRID_N+1:0] eu;
    logic [GRID_N+1:0] em;
    logic [GRID_N+1:0] ed;
    logic [3:0]        cnt;
    logic [GRID_N-1:0] res;
    eu = pad_row(up);
    em = pad_row(mid);
    ed = pad_row(dn);
    res = '0;
    for (int c = 0; c < GRID_N; c++) begin
      cnt = 4'(eu[c]) + 4'(eu[c+1]) + 4'(eu[c+2]) +
            4'(em[c])               + 4'(em[c+2]) +
            4'(ed[c]) + 4'(ed[c+1]) + 4'(ed[c+2]);
      res[c] = (cnt == 4'd3) || (mid[c] && (cnt == 4'd2));
    end
    return res;
  endfunction

  for (genvar r = 0; r < GRID_N; r++) begin : g_rows
    assign cur_rows[r]                       = grid[r*GRID_N +: GRID_N];
    assign next_grid[r*GRID_N +: GRID_N]     = next_rows[r];
  end

  // NOTE: every signal written in an always_comb gets a value on every path
  // (defaults first), otherwise synthesis infers a latch.
  always_comb begin
    up_idx   = (row_ptr == '0) ? LAST_ROW : row_ptr - 1'b1;
    dn_idx   = (row_ptr == LAST_ROW) ? '0 : row_ptr + 1'b1;
    mid_row  = cur_rows[row_ptr];
    up_row   = (WRAP != 0 || row_ptr != '0) ? cur_rows[up_idx] : '0;
    dn_row   = (WRAP != 0 || row_ptr != LAST_ROW) ? cur_rows[dn_idx] : '0;
    calc_row = life_row(up_row, mid_row, dn_row);
  end

  assign trigger   = (run && tick) || step;
  assign next_zero = (next_grid == '0);
  assign next_same = (next_grid == grid);
  assign busy      = (state == CALC) || (state == COMMIT);
  assign halted    = (state == HALT);

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (trigger) state_next = CALC;
      CALC:    if (row_ptr == LAST_ROW) state_next = COMMIT;
      COMMIT:  state_next = (next_zero || next_same) ? HALT : IDLE;
      HALT:    state_next = HALT;
      default: state_next = IDLE;
    endcase
    // Load aborts anything in flight, including a halt.
    if (load) state_next = IDLE;
  end

  // NOTE: state registers use non-blocking assignments so every register in
  // this block samples pre-edge values, independent of statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      row_ptr   <= '0;
      grid      <= '0;
      gen_count <= '0;
      stable    <= 1'b0;
      extinct   <= 1'b0;
      // NOTE: the next-row buffer is reset along with the grid so a COMMIT can
      // never expose rows left over from an aborted or pre-reset computation.
      for (int r = 0; r < GRID_N; r++) next_rows[r] <= '0;
    end else begin
      state <= state_next;
      if (load) begin
        grid      <= seed;
        gen_count <= '0;
        stable    <= 1'b0;
        extinct   <= 1'b0;
        row_ptr   <= '0;
        for (int r = 0; r < GRID_N; r++) next_rows[r] <= '0;
      end else begin
        case (state)
          IDLE: begin
            if (trigger) begin
              row_ptr <= '0;
              for (int r = 0; r < GRID_N; r++) next_rows[r] <= '0;
            end
          end
          CALC: begin
            next_rows[row_ptr] <= calc_row;
            row_ptr            <= (row_ptr == LAST_ROW) ? '0 : row_ptr + 1'b1;
          end
          COMMIT: begin
            grid <= next_grid;
            if (gen_count != '1) gen_count <= gen_count + 1'b1;
            // Extinction wins when an empty grid is also trivially unchanged.
            if (next_zero)      extinct <= 1'b1;
            else if (next_same) stable  <= 1'b1;
          end
          default: ;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_life_step_engine.sv
// Bench for life_step_engine: table of seeds checked through a scoreboard queue,
// plus directed sequences for latency, free-run, abort, halt and reset corners.
module tb_life_step_engine;

  localparam int N = 8;
  localparam int W = N * N;

  localparam logic [W-1:0] BLINKER = 64'h0000_0000_1C00_0000;
  localparam logic [W-1:0] VERT    = 64'h0000_0008_0808_0000;
  localparam logic [W-1:0] BLOCK   = 64'h0000_0000_0000_0303;

  logic clk = 1'b0;
  logic rst, load, run, tick, step;
  logic [W-1:0] seed;

  logic [W-1:0] grid0, grid1, grid2;
  logic [15:0]  gen0, gen1;
  logic [1:0]   gen2;
  logic busy0, halted0, stable0, extinct0;
  logic busy1, halted1, stable1, extinct1;
  logic busy2, halted2, stable2, extinct2;

  life_step_engine #(.GRID_N(N), .WRAP(0), .GEN_W(16)) dut0 (
    .clk(clk), .rst(rst), .seed(seed), .load(load), .run(run), .tick(tick), .step(step),
    .grid(grid0), .gen_count(gen0), .busy(busy0), .halted(halted0),
    .stable(stable0), .extinct(extinct0));

  life_step_engine #(.GRID_N(N), .WRAP(1), .GEN_W(16)) dut1 (
    .clk(clk), .rst(rst), .seed(seed), .load(load), .run(run), .tick(tick), .step(step),
    .grid(grid1), .gen_count(gen1), .busy(busy1), .halted(halted1),
    .stable(stable1), .extinct(extinct1));

  life_step_engine #(.GRID_N(N), .WRAP(0), .GEN_W(2)) dut2 (
    .clk(clk), .rst(rst), .seed(seed), .load(load), .run(run), .tick(tick), .step(step),
    .grid(grid2), .gen_count(gen2), .busy(busy2), .halted(halted2),
    .stable(stable2), .extinct(extinct2));

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [W-1:0] seed;
    logic [W-1:0] exp0;
    logic         h0;
    logic         s0;
    logic         e0;
  } vec_t;

  typedef struct {
    logic [W-1:0] g0;
    logic [W-1:0] g1;
    logic         h0;
    logic         s0;
    logic         e0;
    logic         h1;
  } exp_t;

  exp_t sb[$];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic do_load(input logic [W-1:0] s);
    seed = s;
    load = 1'b1;
    cyc();
    load = 1'b0;
  endtask

  task automatic pulse_step();
    step = 1'b1;
    cyc();
    step = 1'b0;
  endtask

  task automatic wait_idle(input string name);
    int n = 0;
    while (busy0 && n < 30) begin
      cyc();
      n++;
    end
    check({name, " busy timeout"}, 64'(busy0), 64'd0);
  endtask

  // Reference: direct neighbour enumeration over (row, col) coordinates.
  function automatic logic [W-1:0] life_model(input logic [W-1:0] g, input bit wrap);
    logic [W-1:0] nxt;
    int n, rr, cc;
    nxt = '0;
    for (int r = 0; r < N; r++) begin
      for (int c = 0; c < N; c++) begin
        n = 0;
        for (int dr = -1; dr <= 1; dr++) begin
          for (int dc = -1; dc <= 1; dc++) begin
            if (dr == 0 && dc == 0) continue;
            rr = r + dr;
            cc = c + dc;
            if (wrap) begin
              rr = (rr + N) % N;
              cc = (cc + N) % N;
            end else if (rr < 0 || rr >= N || cc < 0 || cc >= N) begin
              continue;
            end
            n += int'(g[rr*N+cc]);
          end
        end
        nxt[r*N+c] = (n == 3) || (g[r*N+c] && n == 2);
      end
    end
    return nxt;
  endfunction

  initial begin
    vec_t vecs[7];
    exp_t e;
    logic [W-1:0] m1, rs;

    rst = 1'b1; load = 1'b0; run = 1'b0; tick = 1'b0; step = 1'b0; seed = '0;
    repeat (2) cyc();
    rst = 1'b0;
    check("reset grid", grid0, 64'd0);
    check("reset gen_count", 64'(gen0), 64'd0);
    check("reset flags", 64'({busy0, halted0, stable0, extinct0}), 64'd0);

    // Table of seeds stepped once on the bounded (WRAP=0) engine.
    vecs[0] = '{BLINKER, VERT, 1'b0, 1'b0, 1'b0};
    vecs[1] = '{BLOCK, BLOCK, 1'b1, 1'b1, 1'b0};
    vecs[2] = '{64'h83, 64'h0, 1'b1, 1'b0, 1'b1};
    vecs[3] = '{64'h0, 64'h0, 1'b1, 1'b0, 1'b1};
    vecs[4] = '{64'h0000_0000_FF00_0000, 64'h0000_007E_7E7E_0000, 1'b0, 1'b0, 1'b0};
    for (int i = 5; i < 7; i++) begin
      rs = {$urandom, $urandom};
      vecs[i].seed = rs;
      vecs[i].exp0 = life_model(rs, 1'b0);
      vecs[i].e0   = (vecs[i].exp0 == '0);
      vecs[i].s0   = !vecs[i].e0 && (vecs[i].exp0 == rs);
      vecs[i].h0   = vecs[i].e0 || vecs[i].s0;
    end

    for (int i = 0; i < 7; i++) begin
      do_load(vecs[i].seed);
      m1   = life_model(vecs[i].seed, 1'b1);
      e.g0 = vecs[i].exp0;
      e.h0 = vecs[i].h0;
      e.s0 = vecs[i].s0;
      e.e0 = vecs[i].e0;
      e.g1 = m1;
      e.h1 = (m1 == '0) || (m1 == vecs[i].seed);
      sb.push_back(e);
      pulse_step();
      wait_idle($sformatf("vec%0d", i));
      e = sb.pop_front();
      check($sformatf("vec%0d grid", i), grid0, e.g0);
      check($sformatf("vec%0d gen_count", i), 64'(gen0), 64'd1);
      check($sformatf("vec%0d halted/stable/extinct", i),
            64'({halted0, stable0, extinct0}), 64'({e.h0, e.s0, e.e0}));
      check($sformatf("vec%0d wrap grid", i), grid1, e.g1);
      check($sformatf("vec%0d wrap halted", i), 64'(halted1), 64'(e.h1));
    end

    // Edge case: 0x83 wraps into a vertical blinker on the torus.
    do_load(64'h83);
    pulse_step();
    wait_idle("edge");
    check("edge wrap grid", grid1, 64'h0100_0000_0000_0101);
    check("edge wrap halted", 64'(halted1), 64'd0);
    check("edge nowrap extinct", 64'({grid0 == '0, halted0, extinct0}), 64'b111);

    // Latency: trigger at edge 0, commit at edge 9, next trigger at edge 10.
    do_load(BLINKER);
    check("load gen_count", 64'(gen0), 64'd0);
    pulse_step();
    check("lat busy after edge0", 64'(busy0), 64'd1);
    repeat (8) cyc();
    check("lat grid held edge8", grid0, BLINKER);
    check("lat busy edge8", 64'(busy0), 64'd1);
    cyc();
    check("lat grid edge9", grid0, VERT);
    check("lat busy edge9", 64'(busy0), 64'd0);
    pulse_step();
    check("lat retrigger edge10", 64'(busy0), 64'd1);
    wait_idle("lat2");
    check("lat gen2", 64'(gen0), 64'd2);
    check("lat grid gen2", grid0, BLINKER);

    // Halt freezes the grid; later triggers are dropped.
    do_load(BLOCK);
    pulse_step();
    wait_idle("block");
    check("block halted", 64'({halted0, stable0, extinct0}), 64'b110);
    pulse_step();
    check("block step ignored busy", 64'(busy0), 64'd0);
    run = 1'b1; tick = 1'b1;
    cyc();
    run = 1'b0; tick = 1'b0;
    repeat (12) cyc();
    check("block gen frozen", 64'(gen0), 64'd1);
    check("block grid frozen", grid0, BLOCK);

    // Free-run with extra ticks landing while busy.
    do_load(BLINKER);
    run = 1'b1;
    for (int t = 0; t < 6; t++) begin
      tick = 1'b1; cyc(); tick = 1'b0;
      repeat (3) cyc();
      tick = 1'b1; cyc(); tick = 1'b0;
      repeat (15) cyc();
    end
    run = 1'b0;
    check("free gen_count", 64'(gen0), 64'd6);
    check("free grid", grid0, BLINKER);
    check("free wrap gen_count", 64'(gen1), 64'd6);
    check("free gen saturate", 64'(gen2), 64'd3);

    // Simultaneous step and run&&tick start exactly one generation.
    do_load(BLINKER);
    run = 1'b1; tick = 1'b1; step = 1'b1;
    cyc();
    tick = 1'b0; step = 1'b0;
    wait_idle("simul");
    repeat (12) cyc();
    run = 1'b0;
    check("simul gen_count", 64'(gen0), 64'd1);
    check("simul grid", grid0, VERT);

    // Abort: load during CALC row 4 discards the computation.
    do_load(BLINKER);
    pulse_step();
    repeat (4) cyc();
    check("abort in calc", 64'(busy0), 64'd1);
    seed = 64'hFF; load = 1'b1;
    cyc();
    load = 1'b0;
    check("abort grid", grid0, 64'hFF);
    check("abort gen/busy", 64'({gen0, busy0}), 64'd0);
    repeat (12) cyc();
    check("abort no commit", grid0, 64'hFF);
    check("abort gen stays", 64'(gen0), 64'd0);

    // Held load tracks seed and blocks triggers.
    seed = 64'h1234; load = 1'b1; step = 1'b1;
    cyc();
    seed = 64'h5678;
    cyc();
    load = 1'b0; step = 1'b0;
    check("held load grid", grid0, 64'h5678);
    check("held load idle", 64'(busy0), 64'd0);

    // Reset during COMMIT: no partial commit.
    do_load(BLINKER);
    pulse_step();
    repeat (8) cyc();
    check("commit busy", 64'(busy0), 64'd1);
    rst = 1'b1;
    cyc();
    rst = 1'b0;
    check("rst commit grid", grid0, 64'd0);
    check("rst commit gen/busy", 64'({gen0, busy0}), 64'd0);

    // Reset during HALT.
    do_load(BLOCK);
    pulse_step();
    wait_idle("halt rst");
    check("pre rst halted", 64'(halted0), 64'd1);
    rst = 1'b1;
    cyc();
    rst = 1'b0;
    check("rst halt flags", 64'({halted0, stable0, extinct0, busy0}), 64'd0);
    check("rst halt grid/gen", {grid0 == '0, gen0 == '0}, 64'b11);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
